id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
// Parametrised Decode->Execute pipeline register for the pipelined core. Carries
// NUM_SRC operand words, extended immediate, destination address, control vector,
// condition field and flags. It adds a valid/ready handshake backed by a 2-entry
// skid buffer, plus flush and saturating stall/bubble counters.
// Control bits of an invalid slot read as zero, so an empty stage is a safe bubble.
// PARAMETERS
// DATA_W      32  operand / immediate width
// NUM_SRC     2   number of register operands carried
// REG_ADDR_W  4   destination register address width
// CTRL_W      8   control vector width (PCSrc,RegWrite,MemtoReg,MemWrite,ALUSrc,FlagWrite,...)
// CNT_W       16  performance counter width
// PORTS
// clk         in   1                  clock, all state updates on rising edge
// reset       in   1                  asynchronous, active-low; 0 = reset
// flush       in   1                  synchronous; discard all held and incoming entries
// in_valid    in   1                  Decode presents an instruction
// in_ready    out  1                  stage can accept (registered)
// in_rd       in   NUM_SRC*DATA_W     operand words, src0 in LSBs
// in_imm      in   DATA_W             extended immediate
// in_wa       in   REG_ADDR_W         write-back address
// in_ctrl     in   CTRL_W             decoded control vector
// in_cond     in   4                  condition field
// in_flags    in   4                  current flags
// out_valid   out  1                  Execute-side instruction valid
// out_ready   in   1                  Execute consumes this cycle
// out_rd/out_imm/out_wa/out_ctrl/out_cond/out_flags  out  same widths as inputs
// cnt_clr     in   1                  synchronous clear of both counters
// stall_cnt   out  CNT_W              cycles with out_valid=1, out_ready=0
// bubble_cnt  out  CNT_W              cycles with out_valid=0
// BEHAVIOUR
// - State: main slot M (drives outputs), skid slot S, each with a valid bit.
// - Reset (reset=0, async): M,S valid=0, all payload=0, counters=0, in_ready=1.
// - accept = in_valid & in_ready; pop = out_valid & out_ready.
// - in_ready = !S.valid (registered, no comb path from out_ready).
// - Latency 1: beat accepted at edge N appears on out_* after edge N; throughput 1/cycle.
// - Next-state, no flush:
//   M empty or popped, S empty: accept -> M, else M.valid=0 if popped.
//   M popped, S full: S -> M; accept (impossible, in_ready=0) ignored.
//   M held (not popped): accept -> S; S held unchanged.
// - Order strictly FIFO; no beat dropped or duplicated without flush.
// - flush=1: next cycle M.valid=S.valid=0; incoming beat discarded even if in_valid
//   and in_ready; in_ready=1 next cycle. Flush wins over pop/accept. Payload regs
//   need not clear.
// - out_ctrl = M.valid ? M.ctrl : 0 (combinational gating). Other out_* show M payload.
// - Counters: sampled each cycle pre-edge; saturate at 2^CNT_W-1; cnt_clr wins over
//   increment; flush cycle counted per pre-edge out_valid/out_ready.
// - Reset asserted mid-stream: all entries lost immediately, outputs to reset values.
// TESTING
// 1 Reset: drive traffic, pull reset low mid-cycle -> out_valid=0, out_ctrl=0,
//   counters=0 immediately, in_ready=1.
// 2 Stream: out_ready=1, in_valid=1 for 8 beats with in_imm=1..8 -> out_imm=1..8
//   on consecutive cycles, one cycle late, in_ready stays 1.
// 3 Back-pressure: out_ready=0 three cycles while pushing A,B,C -> A,B accepted,
//   in_ready=0 after B, C held; out_ready=1 -> outputs A,B,C in order.
// 4 Flush full: M=A, S=B, in_valid=1 with C, flush=1 -> next cycle out_valid=0,
//   out_ctrl=0, in_ready=1; C never appears.
// 5 Counters, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15;
//   cnt_clr together with stall -> stall_cnt=0.
// 6 Simultaneous pop/push with S empty: M=A popped, B accepted same edge -> out=B,
//   S stays empty, in_ready=1.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// Decode -> Execute pipeline register with a valid/ready handshake.
// A main slot drives the Execute side and a one-entry skid slot absorbs the
// beat that arrives in the cycle Execute first stalls, so in_ready can be a
// plain register with no combinational path from out_ready.
// Two saturating counters record stall and bubble cycles.
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 4,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] in_rd,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [REG_ADDR_W-1:0]     in_wa,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [3:0]                in_cond,
    input  logic [3:0]                in_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_SRC*DATA_W-1:0] out_rd,
    output logic [DATA_W-1:0]         out_imm,
    output logic [REG_ADDR_W-1:0]     out_wa,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [3:0]                out_cond,
    output logic [3:0]                out_flags,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    // Packed payload layout: {rd, imm, wa, ctrl, cond, flags}
    localparam int RD_W     = NUM_SRC * DATA_W;
    localparam int FLAGS_LO = 0;
    localparam int COND_LO  = 4;
    localparam int CTRL_LO  = 8;
    localparam int WA_LO    = CTRL_LO + CTRL_W;
    localparam int IMM_LO   = WA_LO + REG_ADDR_W;
    localparam int RD_LO    = IMM_LO + DATA_W;
    localparam int PL_W     = RD_LO + RD_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Slot state
    logic              m_valid_r;
    logic              s_valid_r;
    logic [PL_W-1:0]   m_pl_r;
    logic [PL_W-1:0]   s_pl_r;
    logic              in_ready_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    // Combinational control
    logic              accept_s;
    logic              pop_s;
    logic              m_valid_n_s;
    logic              s_valid_n_s;
    logic              m_load_s;
    logic              m_from_skid_s;
    logic              s_load_s;
    logic [PL_W-1:0]   in_pl_s;
    logic [PL_W-1:0]   m_pl_n_s;
    logic              stall_evt_s;
    logic              bubble_evt_s;

    assign in_pl_s  = {in_rd, in_imm, in_wa, in_ctrl, in_cond, in_flags};
    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = m_valid_r & out_ready;

    // Slot next-state: refill main from skid first, otherwise from input; flush empties both
    always_comb begin
        m_valid_n_s   = m_valid_r;
        s_valid_n_s   = s_valid_r;
        m_load_s      = 1'b0;
        m_from_skid_s = 1'b0;
        s_load_s      = 1'b0;
        if (flush) begin
            m_valid_n_s = 1'b0;
            s_valid_n_s = 1'b0;
        end else if (!m_valid_r || pop_s) begin
            if (s_valid_r) begin
                m_valid_n_s   = 1'b1;
                s_valid_n_s   = 1'b0;
                m_load_s      = 1'b1;
                m_from_skid_s = 1'b1;
            end else if (accept_s) begin
                m_valid_n_s = 1'b1;
                m_load_s    = 1'b1;
            end else begin
                m_valid_n_s = 1'b0;
            end
        end else begin
            if (accept_s && !s_valid_r) begin
                s_valid_n_s = 1'b1;
                s_load_s    = 1'b1;
            end else begin
                s_valid_n_s = s_valid_r;
            end
        end
    end

    // Main slot load source select
    always_comb begin
        if (m_from_skid_s) begin
            m_pl_n_s = s_pl_r;
        end else begin
            m_pl_n_s = in_pl_s;
        end
    end

    // Valid bits and registered in_ready (ready whenever the skid slot will be empty)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_r  <= 1'b0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            m_valid_r  <= m_valid_n_s;
            s_valid_r  <= s_valid_n_s;
            in_ready_r <= ~s_valid_n_s;
        end
    end

    // Main slot payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pl_r <= {PL_W{1'b0}};
        end else if (m_load_s) begin
            m_pl_r <= m_pl_n_s;
        end else begin
            m_pl_r <= m_pl_r;
        end
    end

    // Skid slot payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_pl_r <= {PL_W{1'b0}};
        end else if (s_load_s) begin
            s_pl_r <= in_pl_s;
        end else begin
            s_pl_r <= s_pl_r;
        end
    end

    assign stall_evt_s  = m_valid_r & ~out_ready;
    assign bubble_evt_s = ~m_valid_r;

    // Saturating stall counter; clear has priority over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating bubble counter; clear has priority over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (bubble_evt_s && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    // Outputs; control bits are gated so an empty stage is a harmless bubble
    assign in_ready   = in_ready_r;
    assign out_valid  = m_valid_r;
    assign out_rd     = m_pl_r[RD_LO +: RD_W];
    assign out_imm    = m_pl_r[IMM_LO +: DATA_W];
    assign out_wa     = m_pl_r[WA_LO +: REG_ADDR_W];
    assign out_ctrl   = m_valid_r ? m_pl_r[CTRL_LO +: CTRL_W] : {CTRL_W{1'b0}};
    assign out_cond   = m_pl_r[COND_LO +: 4];
    assign out_flags  = m_pl_r[FLAGS_LO +: 4];
    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (CNT_W=4 so saturation is reachable).
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int NUM_SRC = 2;
    localparam int RAW = 4;
    localparam int CW = 8;
    localparam int CNT_W = 4;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_SRC*DATA_W-1:0] in_rd;
    logic [DATA_W-1:0]         in_imm;
    logic [RAW-1:0]            in_wa;
    logic [CW-1:0]             in_ctrl;
    logic [3:0]                in_cond;
    logic [3:0]                in_flags;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_SRC*DATA_W-1:0] out_rd;
    logic [DATA_W-1:0]         out_imm;
    logic [RAW-1:0]            out_wa;
    logic [CW-1:0]             out_ctrl;
    logic [3:0]                out_cond;
    logic [3:0]                out_flags;
    logic                      cnt_clr;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    id_ex_pipe_reg #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .REG_ADDR_W(RAW), .CTRL_W(CW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_imm(in_imm), .in_wa(in_wa), .in_ctrl(in_ctrl),
        .in_cond(in_cond), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_imm(out_imm), .out_wa(out_wa), .out_ctrl(out_ctrl),
        .out_cond(out_cond), .out_flags(out_flags),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ctrl_of(input logic [31:0] t);
        ctrl_of = t[7:0] | 8'h01;
    endfunction

    function automatic logic [63:0] rd_of(input logic [31:0] t);
        rd_of = {t ^ 32'hA5A5_A5A5, t};
    endfunction

    task automatic drive(input logic v, input logic [31:0] t);
        in_valid = v;
        in_imm   = t;
        in_rd    = rd_of(t);
        in_wa    = t[3:0] ^ 4'hF;
        in_ctrl  = ctrl_of(t);
        in_cond  = t[3:0];
        in_flags = ~t[3:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare beats Execute consumes, then record beats Decode hands over
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (!flush && out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got imm=%0h, expected no beat", out_imm);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    if (out_imm !== e || out_rd !== rd_of(e) || out_ctrl !== ctrl_of(e) ||
                        out_wa !== (e[3:0] ^ 4'hF) || out_cond !== e[3:0] || out_flags !== ~e[3:0]) begin
                        n_err++;
                        $display("FAIL sb_beat: got imm=%0h ctrl=%0h wa=%0h, expected imm=%0h ctrl=%0h wa=%0h",
                                 out_imm, out_ctrl, out_wa, e, ctrl_of(e), e[3:0] ^ 4'hF);
                    end
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back(in_imm);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0);
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 8'h00 || out_imm !== 32'h0 ||
            stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_init: got v=%b rdy=%b ctrl=%0h imm=%0h st=%0d bu=%0d, expected 0 1 0 0 0 0",
                     out_valid, in_ready, out_ctrl, out_imm, stall_cnt, bubble_cnt);
        end
        @(negedge clk); #1; reset = 1'b1;
        tick();
        drive(1'b1, 32'h11); tick();
        drive(1'b1, 32'h12); tick();
        drive(1'b1, 32'h13); tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== ctrl_of(32'h11) || in_ready !== 1'b0 || stall_cnt !== 4'd2) begin
            n_err++;
            $display("FAIL reset_pre: got v=%b ctrl=%0h rdy=%b st=%0d, expected 1 %0h 0 2",
                     out_valid, out_ctrl, in_ready, stall_cnt, ctrl_of(32'h11));
        end
        #2; reset = 1'b0; #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1 ||
            stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b ctrl=%0h rdy=%b st=%0d bu=%0d, expected 0 0 1 0 0",
                     out_valid, out_ctrl, in_ready, stall_cnt, bubble_cnt);
        end
        drive(1'b0, 32'h0);
        @(negedge clk); #1; reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_imm !== i || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b imm=%0d rdy=%b, expected 1 %0d 1", i, out_valid, out_imm, in_ready, i);
            end
        end
        drive(1'b0, 32'h0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            n_err++;
            $display("FAIL stream_drain: got v=%b ctrl=%0h, expected 0 0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hA1; exp_seq[1] = 32'hB2; exp_seq[2] = 32'hC3;
        out_ready = 1'b0;
        drive(1'b1, exp_seq[0]); tick();
        drive(1'b1, exp_seq[1]); tick();
        n_cmp++;
        if (in_ready !== 1'b0 || out_imm !== exp_seq[0]) begin
            n_err++;
            $display("FAIL bp_full: got rdy=%b imm=%0h, expected 0 %0h", in_ready, out_imm, exp_seq[0]);
        end
        drive(1'b1, exp_seq[2]); tick();
        n_cmp++;
        if (in_ready !== 1'b0 || out_imm !== exp_seq[0] || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: got rdy=%b imm=%0h, expected 0 %0h", in_ready, out_imm, exp_seq[0]);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_imm !== exp_seq[i] || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_out_%0d: got v=%b imm=%0h rdy=%b, expected 1 %0h 1", i, out_valid, out_imm, in_ready, exp_seq[i]);
            end
            if (i == 1) drive(1'b1, exp_seq[2]);
            else drive(1'b0, 32'h0);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_empty: got v=%b pending=%0d, expected 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hA4); tick();
        drive(1'b1, 32'hB5); tick();
        drive(1'b1, 32'hC6); flush = 1'b1; tick();
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full: got v=%b ctrl=%0h rdy=%b, expected 0 0 1", out_valid, out_ctrl, in_ready);
        end
        drive(1'b1, 32'hD7); tick();
        drive(1'b1, 32'hE8); flush = 1'b1; tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready: got v=%b rdy=%b, expected 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            n_err++;
            $display("FAIL flush_gone: got v=%b imm=%0h, expected no valid beat", out_valid, out_imm);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 32'h5A); tick();
        out_ready = 1'b1;
        drive(1'b1, 32'h6B); tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_imm !== 32'h6B || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_swap: got v=%b imm=%0h rdy=%b, expected 1 6b 1", out_valid, out_imm, in_ready);
        end
        drive(1'b0, 32'h0); tick();
        n_cmp++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_skid_empty: got v=%b imm=%0h pending=%0d, expected 0 - 0", out_valid, out_imm, sb.size());
        end
    endtask

    task automatic test_counters();
        out_ready = 1'b0;
        drive(1'b1, 32'h77); tick();
        drive(1'b0, 32'h0);
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        n_cmp++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL cnt_clr: got st=%0d bu=%0d, expected 0 0", stall_cnt, bubble_cnt);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5 || k == 15 || k == 20) begin
                n_cmp++;
                if (stall_cnt !== ((k > 15) ? 15 : k)) begin
                    n_err++;
                    $display("FAIL stall_%0d: got %0d, expected %0d", k, stall_cnt, (k > 15) ? 15 : k);
                end
            end
        end
        n_cmp++;
        if (bubble_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL bubble_hold: got %0d, expected 0", bubble_cnt);
        end
        cnt_clr = 1'b1; tick();
        cnt_clr = 1'b0;
        n_cmp++;
        if (stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL stall_clr: got %0d, expected 0", stall_cnt);
        end
        out_ready = 1'b1; tick();
        for (int k = 0; k < 3; k++) tick();
        n_cmp++;
        if (bubble_cnt !== 4'd3 || stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL bubble_3: got bu=%0d st=%0d, expected 3 0", bubble_cnt, stall_cnt);
        end
        for (int k = 0; k < 20; k++) tick();
        n_cmp++;
        if (bubble_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL bubble_sat: got %0d, expected 15", bubble_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_counters();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending beats, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
